// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised serial pattern detector with match counter
//
// Purpose: watches a serial bit stream and flags when the last N accepted bits
// equal a loadable pattern, in overlapping or non-overlapping mode, and keeps a
// saturating count of matches.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en, din           sample qualifier and serial data bit
//   ovl               1 = overlapping detection, 0 = non-overlapping
//   cfg_load, cfg_pat load a new pattern (MSB is the first bit received)
//   cnt_clr           synchronous clear of the match counter
//   match             combinational detect flag, same cycle as the final bit
//   match_q           match delayed by one cycle
//   match_cnt         saturating match count

module seq_detect_param #(
    parameter int             N         = 4,
    parameter logic [N-1:0]   RESET_PAT = N'(4'b1101),
    parameter int             CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             ovl,
    input  logic             cfg_load,
    input  logic [N-1:0]     cfg_pat,
    input  logic             cnt_clr,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               FW       = $clog2(N);
    localparam logic [FW-1:0]    FILL_MAX = FW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [N-1:0]     pat_q, pat_d;
    logic [N-2:0]     hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_q_q, match_q_d;

    // History plus the current bit, oldest bit at the MSB.
    logic [N-1:0]     window;

    assign window = {hist_q, din};

    // fill is held at 0 throughout reset, so match cannot assert during reset.
    assign match = en & ~cfg_load & (fill_q == FILL_MAX) & (window == pat_q);

    always_comb begin
        pat_d     = pat_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        match_q_d = match;

        if (cfg_load) begin
            // The sample arriving with a load is dropped; old history is
            // invalidated by clearing fill.
            pat_d  = cfg_pat;
            fill_d = '0;
        end else if (en) begin
            hist_d = window[N-2:0];
            if (match && !ovl) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
        end

        // A clear coinciding with a match still counts that match.
        if (cnt_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q     <= RESET_PAT;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            match_q_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            match_q_q <= match_q_d;
        end
    end

    assign match_q   = match_q_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - self-checking bench for seq_detect_param

module tb_seq_detect_param;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, din, ovl, cfg_load, cnt_clr;
    logic [N-1:0] cfg_pat;
    logic         match, match_q;
    logic [7:0]   match_cnt;
    logic         match2, match_q2;
    logic [1:0]   match_cnt2;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of accepted bits since the last flush.
    bit           m_hist[$];
    logic [N-1:0] m_pat;
    int           m_cnt, m_cnt2;
    logic         m_mq;

    always #5 clk = ~clk;

    seq_detect_param #(.N(N), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .ovl(ovl),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cnt_clr(cnt_clr),
        .match(match), .match_q(match_q), .match_cnt(match_cnt)
    );

    seq_detect_param #(.N(N), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .ovl(ovl),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cnt_clr(cnt_clr),
        .match(match2), .match_q(match_q2), .match_cnt(match_cnt2)
    );

    function automatic logic model_match(logic i_en, logic i_din, logic i_load);
        logic [N-1:0] w;
        if (!i_en || i_load || m_hist.size() != N - 1) return 1'b0;
        w = '0;
        foreach (m_hist[k]) w = {w[N-2:0], logic'(m_hist[k])};
        w = {w[N-2:0], i_din};
        return (w == m_pat);
    endfunction

    task automatic model_reset();
        m_pat = 4'b1101;
        m_hist.delete();
        m_cnt  = 0;
        m_cnt2 = 0;
        m_mq   = 1'b0;
    endtask

    // Drives one cycle (called in the low clock phase), returns the observed and
    // modelled match, advances the model at the edge and ends at the next negedge.
    task automatic step(input logic i_en, input logic i_din, input logic i_ovl,
                        input logic i_load, input logic [N-1:0] i_pat, input logic i_clr,
                        output logic o_m, output logic o_m2, output logic e_m);
        en = i_en; din = i_din; ovl = i_ovl;
        cfg_load = i_load; cfg_pat = i_pat; cnt_clr = i_clr;
        #1;
        o_m  = match;
        o_m2 = match2;
        e_m  = model_match(i_en, i_din, i_load);
        @(posedge clk);
        if (i_load) begin
            m_pat = i_pat;
            m_hist.delete();
        end else if (i_en) begin
            if (e_m && !i_ovl) begin
                m_hist.delete();
            end else begin
                m_hist.push_back(i_din);
                if (m_hist.size() > N - 1) void'(m_hist.pop_front());
            end
        end
        if (i_clr) begin
            m_cnt  = e_m ? 1 : 0;
            m_cnt2 = e_m ? 1 : 0;
        end else if (e_m) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        m_mq = e_m;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        en = 1'b1; din = 1'b1; ovl = 1'b0; cfg_load = 1'b0; cfg_pat = '0; cnt_clr = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match: got %b want 0", match); end
        checks++; if (match_q !== 1'b0) begin errors++; $display("FAIL reset_match_q: got %b want 0", match_q); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
        checks++; if (match_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2: got %0d want 0", match_cnt2); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_stream(input string name, input logic [6:0] s, input logic [6:0] e,
                              input logic i_ovl, input int exp_cnt);
        logic om, om2, em;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s[6-i], i_ovl, 1'b0, '0, 1'b0, om, om2, em);
            checks++;
            if (om !== e[6-i]) begin
                errors++; $display("FAIL %s_match[%0d]: got %b want %b", name, i + 1, om, e[6-i]);
            end
            if (i == 3) begin
                checks++;
                if (match_q !== 1'b1) begin
                    errors++; $display("FAIL %s_match_q: got %b want 1", name, match_q);
                end
            end
        end
        checks++;
        if (match_cnt !== 8'(exp_cnt)) begin
            errors++; $display("FAIL %s_cnt: got %0d want %0d", name, match_cnt, exp_cnt);
        end
    endtask

    task automatic test_non_overlap();
        run_stream("non_overlap", 7'b1101101, 7'b0001000, 1'b0, 1);
    endtask

    task automatic test_overlap();
        run_stream("overlap", 7'b1101101, 7'b0001001, 1'b1, 2);
    endtask

    task automatic test_en_gaps();
        logic [3:0] s;
        logic om, om2, em;
        s = 4'b1101;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s[3-i], 1'b0, 1'b0, '0, 1'b0, om, om2, em);
            checks++;
            if (om !== (i == 3)) begin
                errors++; $display("FAIL gaps_valid[%0d]: got %b want %b", i, om, (i == 3));
            end
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'($urandom), 1'b0, 1'b0, '0, 1'b0, om, om2, em);
                    checks++;
                    if (om !== 1'b0) begin
                        errors++; $display("FAIL gaps_idle[%0d.%0d]: got %b want 0", i, g, om);
                    end
                end
            end
        end
        checks++;
        if (match_cnt !== 8'd1) begin errors++; $display("FAIL gaps_cnt: got %0d want 1", match_cnt); end
    endtask

    task automatic test_reload();
        logic [3:0] s;
        logic om, om2, em;
        do_reset();
        s = 4'b1100;
        for (int i = 0; i < 3; i++) step(1'b1, s[3-i], 1'b0, 1'b0, '0, 1'b0, om, om2, em);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, om, om2, em);
        checks++;
        if (om !== 1'b0) begin errors++; $display("FAIL reload_cycle: got %b want 0", om); end
        s = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s[3-i], 1'b0, 1'b0, '0, 1'b0, om, om2, em);
            checks++;
            if (om !== (i == 3)) begin
                errors++; $display("FAIL reload_match[%0d]: got %b want %b", i, om, (i == 3));
            end
        end
    endtask

    // Runs straight after test_reload so the loaded pattern 0110 is live.
    task automatic test_reset_mid();
        logic [4:0] s;
        logic om, om2, em;
        s = 5'b01100;
        for (int i = 0; i < 4; i++) step(1'b1, s[4-i], 1'b0, 1'b0, '0, 1'b0, om, om2, em);
        checks++;
        if (match_cnt !== 8'd2) begin errors++; $display("FAIL midrst_pre_cnt: got %0d want 2", match_cnt); end
        s = 5'b11000;
        for (int i = 0; i < 3; i++) step(1'b1, s[4-i], 1'b0, 1'b0, '0, 1'b0, om, om2, em);
        en = 1'b1; din = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL midrst_match: got %b want 0", match); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", match_cnt); end
        checks++; if (match_q !== 1'b0) begin errors++; $display("FAIL midrst_match_q: got %b want 0", match_q); end
        #1;
        rst_n = 1'b1;
        model_reset();
        s = 5'b11101;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, s[4-i], 1'b0, 1'b0, '0, 1'b0, om, om2, em);
            checks++;
            if (om !== (i == 4)) begin
                errors++; $display("FAIL midrst_after[%0d]: got %b want %b", i, om, (i == 4));
            end
        end
    endtask

    task automatic test_counter();
        logic [15:0] s;
        logic om, om2, em;
        do_reset();
        s = 16'b1101101101101101;
        for (int i = 0; i < 16; i++) step(1'b1, s[15-i], 1'b1, 1'b0, '0, 1'b0, om, om2, em);
        checks++;
        if (match_cnt2 !== 2'd3) begin errors++; $display("FAIL cnt_saturate: got %0d want 3", match_cnt2); end
        checks++;
        if (match_cnt !== 8'd5) begin errors++; $display("FAIL cnt_wide: got %0d want 5", match_cnt); end
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, om, om2, em);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, om, om2, em);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, om, om2, em);
        checks++;
        if (om2 !== 1'b1) begin errors++; $display("FAIL cnt_clr_cycle_match: got %b want 1", om2); end
        checks++;
        if (match_cnt2 !== 2'd1) begin errors++; $display("FAIL cnt_clr_match: got %0d want 1", match_cnt2); end
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, om, om2, em);
        checks++;
        if (match_cnt2 !== 2'd0 || match_cnt !== 8'd0) begin
            errors++; $display("FAIL cnt_clr_idle: got %0d/%0d want 0/0", match_cnt2, match_cnt);
        end
    endtask

    task automatic test_random();
        logic om, om2, em;
        logic r_en, r_ld, r_clr;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r_en  = ($urandom_range(0, 3) != 0);
            r_ld  = ($urandom_range(0, 39) == 0);
            r_clr = ($urandom_range(0, 59) == 0);
            step(r_en, 1'($urandom), 1'($urandom), r_ld, N'($urandom), r_clr, om, om2, em);
            checks++;
            if (om !== em || om2 !== em) begin
                errors++; $display("FAIL rand_match[%0d]: got %b/%b want %b", c, om, om2, em);
            end
            checks++;
            if (match_q !== m_mq || match_q2 !== m_mq) begin
                errors++; $display("FAIL rand_match_q[%0d]: got %b/%b want %b", c, match_q, match_q2, m_mq);
            end
            checks++;
            if (match_cnt !== 8'(m_cnt) || match_cnt2 !== 2'(m_cnt2)) begin
                errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d",
                                   c, match_cnt, match_cnt2, m_cnt, m_cnt2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_non_overlap();
        test_overlap();
        test_en_gaps();
        test_reload();
        test_reset_mid();
        test_counter();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
